pp_detect_sched: RTL and testbench
==================================

Name: pp_detect_sched

Overview:
- Round-robin scheduler that shares one serial sequence detector (single-bit input w, single-bit Moore output z, active-high reset) among N_REQ requesters.
- A granted requester's parallel word is cleared into the detector, shifted in MSB-first, and the detector's match pulses are counted.
- The match count is returned with a done strobe.
- Sits between requester logic and the detector instance; sole driver of the detector's w and reset.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester index width, ceil(log2(N_REQ))
- DATA_W, 8, bits per word shifted into the detector
- CNT_W, 4, match counter width (saturating)

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Rst  in  1  synchronous reset, active-low
- req  in  N_REQ  request per requester; level, held until matching done
- data  in  N_REQ*DATA_W  word per requester; requester i at bits [i*DATA_W +: DATA_W]
- grant  out  N_REQ  one-hot grant
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion strobe
- done_id  out  ID_W  index of completed requester, valid with done, held after
- match_cnt  out  CNT_W  matches counted for the completed word, held until next done
- det_w  out  1  serial bit to detector w
- det_rst  out  1  active-high reset to detector
- det_z  in  1  detector output z

Behaviour:
- All outputs registered.
- Reset (Rst low at edge):
  - state=IDLE; grant=0, busy=0, done=0, done_id=0, match_cnt=0, det_w=0, det_rst=1.
  - RR pointer=N_REQ-1, so requester 0 has first priority.
  - det_rst clears on the first edge with Rst high.
  - Reset mid-operation aborts immediately; no done is issued.
- IDLE:
  - If any req is set, pick the first set bit searching from pointer+1 upward, wrapping modulo N_REQ.
  - Set grant one-hot, latch that requester's data into shift register, pointer<=winner, go CLR.
  - Otherwise stay in IDLE.
- CLR (1 cycle): det_rst=1, det_w=0, counter<=0, go SHIFT with bit index k=0.
- SHIFT (DATA_W cycles, k=0..DATA_W-1):
  - det_w = latched bit [DATA_W-1-k].
  - On each edge with k>=1, if det_z=1 increment counter, saturating at 2^CNT_W-1.
  - After k=DATA_W-1, go DRAIN.
- DRAIN (1 cycle):
  - det_w=0; sample det_z once more.
  - This gives DATA_W samples in total: the Moore output after each consumed bit.
  - Go DONE.
- DONE (1 cycle): done=1, done_id=winner, match_cnt=counter; go IDLE, grant cleared on exit.
- Latency: grant rises the edge after req is sampled in IDLE; done rises DATA_W+2 cycles after grant rises; grant falls with done.
- Back-to-back:
  - Re-arbitration happens in the IDLE cycle after DONE, so there is one idle cycle minimum between jobs.
  - A requester whose req is still set after its done is re-granted only after all other pending requesters (RR fairness).
- req or data changes after grant are ignored; the job completes with the latched word.
- req not dropped by the requester is treated as a new request.
- Simultaneous requests are resolved purely by the RR pointer; no fixed priority after the first grant.
- det_rst is asserted only in reset and CLR, so detector state never carries over between jobs.

Test Plan:
Bench detector stub: Moore, z=1 when last 3 consumed bits are 111, overlapping.
- Reset, req=4'b0001, data0=8'hFF -> grant=0001 next cycle; det_w=1 for 8 cycles; done 10 cycles after grant; done_id=0, match_cnt=6.
- req0 with data0=8'hE7 -> match_cnt=2. Then data0=8'h00 -> match_cnt=0; det_rst pulses once per job.
- req=4'b1111 held continuously -> grant order 0001,0010,0100,1000,0001; done_id 0,1,2,3,0; one idle cycle between jobs.
- CNT_W=2, data=8'hFF -> match_cnt saturates at 3 and does not wrap.
- Rst low during SHIFT of job on req2 -> next cycle all outputs at reset values, no done; after release req=4'b0100 -> requester 2 granted and job restarts from CLR.
- Change data1 and drop req1 mid-job -> job completes with the latched word; no re-grant of 1 afterwards.

Source files
------------

// File: rtl/pp_detect_sched.sv
// pp_detect_sched: round-robin scheduler sharing one serial sequence detector among N_REQ
// requesters. The granted requester's word is latched, the detector is cleared, the word is
// shifted in MSB-first on det_w, and the detector's Moore output det_z is counted
// (saturating) over one sample per consumed bit. The count is returned with a done strobe.
//
// Ports:
//   Clk        clock, all state updates on the rising edge
//   Rst        synchronous reset, active-low
//   req        per-requester level request, held until its done
//   data       per-requester word, requester i at [i*DATA_W +: DATA_W]
//   grant      one-hot grant, high from arbitration until the done cycle ends
//   busy       high in every state except idle
//   done       one-cycle completion strobe
//   done_id    index of the completed requester, held until the next done
//   match_cnt  matches counted for the completed word, held until the next done
//   det_w      serial bit to the detector
//   det_rst    active-high detector reset
//   det_z      detector output
module pp_detect_sched #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ID_W   = 2,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    done,
    output logic [ID_W-1:0]         done_id,
    output logic [CNT_W-1:0]        match_cnt,
    output logic                    det_w,
    output logic                    det_rst,
    input  logic                    det_z
);

    localparam int unsigned KW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [KW-1:0] KLast = KW'(DATA_W - 1);

    typedef enum logic [2:0] {StIdle, StClr, StShift, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ID_W-1:0]     done_id_q, done_id_d;
    logic [CNT_W-1:0]    match_q, match_d;
    logic                det_w_q, det_w_d;
    logic                det_rst_q, det_rst_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [KW-1:0]       k_q, k_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                found;
    logic [ID_W-1:0]     win_idx;
    logic [CNT_W-1:0]    cnt_sat;

    assign cnt_sat = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // Round-robin search: first set request starting just above the last winner.
    always_comb begin
        int unsigned cand;
        found   = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = (32'(ptr_q) + i) % N_REQ;
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        match_d   = match_q;
        det_w_d   = 1'b0;
        det_rst_d = 1'b0;
        ptr_d     = ptr_q;
        shreg_d   = shreg_q;
        k_d       = k_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d          = StClr;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    shreg_d          = data[win_idx*DATA_W +: DATA_W];
                    ptr_d            = win_idx;
                    det_rst_d        = 1'b1;
                end
            end
            StClr: begin
                cnt_d   = '0;
                k_d     = '0;
                det_w_d = shreg_q[DATA_W-1];
                shreg_d = shreg_q << 1;
                state_d = StShift;
            end
            StShift: begin
                // At k=0 the detector output still reflects its cleared state.
                if (k_q != '0 && det_z) begin
                    cnt_d = cnt_sat;
                end
                if (k_q == KLast) begin
                    state_d = StDrain;
                end else begin
                    k_d     = k_q + 1'b1;
                    det_w_d = shreg_q[DATA_W-1];
                    shreg_d = shreg_q << 1;
                end
            end
            StDrain: begin
                // Last sample: detector output after the final consumed bit.
                match_d   = det_z ? cnt_sat : cnt_q;
                done_d    = 1'b1;
                done_id_d = ptr_q;
                state_d   = StDone;
            end
            StDone: begin
                grant_d = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            match_q   <= '0;
            det_w_q   <= 1'b0;
            det_rst_q <= 1'b1;
            ptr_q     <= ID_W'(N_REQ - 1);
            shreg_q   <= '0;
            k_q       <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            match_q   <= match_d;
            det_w_q   <= det_w_d;
            det_rst_q <= det_rst_d;
            ptr_q     <= ptr_d;
            shreg_q   <= shreg_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign match_cnt = match_q;
    assign det_w     = det_w_q;
    assign det_rst   = det_rst_q;

endmodule

// File: tb/tb_pp_detect_sched.sv
// Testbench for pp_detect_sched: two instances (4-bit and 2-bit match counters) share the
// stimulus, each driving its own "111" overlapping Moore detector stub.
module tb_pp_detect_sched;

    localparam int N = 4;
    localparam int DW = 8;
    localparam int IDW = 2;

    logic            Clk = 1'b0;
    logic            Rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] data = '0;

    logic [N-1:0]    grant, grant_s;
    logic            busy, busy_s, done, done_s;
    logic [IDW-1:0]  done_id, done_id_s;
    logic [3:0]      match_cnt;
    logic [1:0]      match_cnt_s;
    logic            det_w, det_w_s, det_rst, det_rst_s, det_z, det_z_s;
    logic [2:0]      hist, hist_s;

    int n_cmp = 0;
    int n_fail = 0;
    int ptr_m = N - 1;

    always #5 Clk = ~Clk;

    pp_detect_sched #(.N_REQ(N), .ID_W(IDW), .DATA_W(DW), .CNT_W(4)) dut (
        .Clk(Clk), .Rst(Rst), .req(req), .data(data), .grant(grant), .busy(busy),
        .done(done), .done_id(done_id), .match_cnt(match_cnt), .det_w(det_w),
        .det_rst(det_rst), .det_z(det_z)
    );

    pp_detect_sched #(.N_REQ(N), .ID_W(IDW), .DATA_W(DW), .CNT_W(2)) dut_s (
        .Clk(Clk), .Rst(Rst), .req(req), .data(data), .grant(grant_s), .busy(busy_s),
        .done(done_s), .done_id(done_id_s), .match_cnt(match_cnt_s), .det_w(det_w_s),
        .det_rst(det_rst_s), .det_z(det_z_s)
    );

    // Detector stubs: z=1 when the last three consumed bits are all ones.
    always_ff @(posedge Clk) hist <= det_rst ? 3'b000 : {hist[1:0], det_w};
    always_ff @(posedge Clk) hist_s <= det_rst_s ? 3'b000 : {hist_s[1:0], det_w_s};
    assign det_z   = &hist;
    assign det_z_s = &hist_s;

    // Reference: number of bit positions (MSB-first) at which a run of >=3 ones is present.
    function automatic int count111(input logic [DW-1:0] w);
        int run = 0;
        int c = 0;
        for (int j = DW - 1; j >= 0; j--) begin
            run = w[j] ? run + 1 : 0;
            if (run >= 3) c++;
        end
        return c;
    endfunction

    function automatic int sat(input int c, input int wbits);
        int mx = (1 << wbits) - 1;
        return (c > mx) ? mx : c;
    endfunction

    function automatic int pick(input int ptr, input logic [N-1:0] r);
        for (int i = 1; i <= N; i++) if (r[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Observes one job starting in the clear cycle; optionally changes req/data mid-job.
    // Returns cycles to done (0 if never seen), the serial bits seen, and det_rst cycles.
    task automatic run_job(input int chg_at, input logic [N-1:0] chg_req,
                           input logic [N*DW-1:0] chg_data, output int cyc,
                           output logic [DW-1:0] wb, output int rc);
        cyc = 0;
        wb  = '0;
        rc  = 0;
        for (int c = 1; c <= 20; c++) begin
            if (det_rst) rc++;
            if (c == chg_at) begin
                req  = chg_req;
                data = chg_data;
            end
            tick;
            if (c <= DW) wb = {wb[DW-2:0], det_w};
            if (done) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        Rst  = 1'b0;
        req  = '0;
        data = '0;
        tick;
        tick;
        n_cmp++;
        if ({grant, busy, done, done_id, match_cnt, det_w, det_rst} !== 14'b0000_0_0_00_0000_0_1) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=%b",
                     {grant, busy, done, done_id, match_cnt, det_w, det_rst}, 14'b1);
        end
        Rst = 1'b1;
        ptr_m = N - 1;
        tick;
        n_cmp++;
        if (det_rst !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release det_rst=%b busy=%b exp 0 0", det_rst, busy);
        end
    endtask

    task automatic test_single(input logic [DW-1:0] w);
        int cyc, rc, exp;
        logic [DW-1:0] wb;
        data = '0;
        data[DW-1:0] = w;
        req = 4'b0001;
        tick;
        exp = pick(ptr_m, req);
        ptr_m = exp;
        n_cmp++;
        if (grant !== 4'(1 << exp) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant got=%b busy=%b exp=%b", grant, busy, 4'(1 << exp));
        end
        run_job(0, req, data, cyc, wb, rc);
        n_cmp++;
        if (cyc !== 10) begin
            n_fail++;
            $display("FAIL single_latency got=%0d exp=10", cyc);
        end
        n_cmp++;
        if (wb !== w || rc !== 1) begin
            n_fail++;
            $display("FAIL single_serial bits=%h rst_cycles=%0d exp=%h 1", wb, rc, w);
        end
        n_cmp++;
        if (done_id !== 2'd0 || match_cnt !== 4'(sat(count111(w), 4))) begin
            n_fail++;
            $display("FAIL single_result id=%0d cnt=%0d exp 0 %0d", done_id, match_cnt,
                     sat(count111(w), 4));
        end
        n_cmp++;
        if (match_cnt_s !== 2'(sat(count111(w), 2))) begin
            n_fail++;
            $display("FAIL single_sat cnt=%0d exp=%0d", match_cnt_s, sat(count111(w), 2));
        end
        req = '0;
        tick;
        n_cmp++;
        if (done !== 1'b0 || grant !== 4'b0 || busy !== 1'b0 ||
            match_cnt !== 4'(sat(count111(w), 4))) begin
            n_fail++;
            $display("FAIL single_after done=%b grant=%b busy=%b cnt=%0d", done, grant, busy,
                     match_cnt);
        end
    endtask

    task automatic test_rr;
        int cyc, rc, exp;
        logic [DW-1:0] wb;
        Rst = 1'b0;
        tick;
        Rst = 1'b1;
        ptr_m = N - 1;
        data = {8'hE7, 8'h00, 8'hFF, 8'h7F};
        req = 4'b1111;
        tick;
        for (int j = 0; j < 5; j++) begin
            exp = pick(ptr_m, req);
            ptr_m = exp;
            n_cmp++;
            if (grant !== 4'(1 << exp)) begin
                n_fail++;
                $display("FAIL rr_grant job=%0d got=%b exp=%b", j, grant, 4'(1 << exp));
            end
            run_job(0, req, data, cyc, wb, rc);
            n_cmp++;
            if (cyc !== 10 || done_id !== 2'(exp) ||
                match_cnt !== 4'(sat(count111(data[exp*DW +: DW]), 4))) begin
                n_fail++;
                $display("FAIL rr_done job=%0d cyc=%0d id=%0d cnt=%0d exp 10 %0d %0d", j, cyc,
                         done_id, match_cnt, exp, sat(count111(data[exp*DW +: DW]), 4));
            end
            if (j == 4) req = '0;
            tick;
            n_cmp++;
            if (grant !== 4'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_idle_gap job=%0d grant=%b busy=%b exp 0 0", j, grant, busy);
            end
            if (j < 4) tick;
        end
    endtask

    task automatic test_ignore;
        int cyc, rc, exp;
        logic [DW-1:0] wb;
        data = '0;
        data[1*DW +: DW] = 8'hFF;
        req = 4'b0010;
        tick;
        exp = pick(ptr_m, req);
        ptr_m = exp;
        n_cmp++;
        if (grant !== 4'(1 << exp)) begin
            n_fail++;
            $display("FAIL ignore_grant got=%b exp=%b", grant, 4'(1 << exp));
        end
        run_job(4, 4'b0000, '0, cyc, wb, rc);
        n_cmp++;
        if (cyc !== 10 || wb !== 8'hFF || done_id !== 2'd1 || match_cnt !== 4'd6) begin
            n_fail++;
            $display("FAIL ignore_latched cyc=%0d bits=%h id=%0d cnt=%0d exp 10 ff 1 6", cyc,
                     wb, done_id, match_cnt);
        end
        for (int c = 0; c < 3; c++) begin
            tick;
            n_cmp++;
            if (grant !== 4'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL ignore_no_regrant cyc=%0d grant=%b busy=%b", c, grant, busy);
            end
        end
    endtask

    task automatic test_reset_mid;
        int cyc, rc, exp;
        logic [DW-1:0] wb;
        logic [DW-1:0] w;
        w = DW'($urandom);
        data = '0;
        data[2*DW +: DW] = w;
        req = 4'b0100;
        tick;
        ptr_m = pick(ptr_m, req);
        n_cmp++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL rstmid_grant got=%b exp=0100", grant);
        end
        for (int c = 0; c < 4; c++) tick;
        Rst = 1'b0;
        tick;
        n_cmp++;
        if ({grant, busy, done, done_id, match_cnt, det_w, det_rst} !== 14'b0000_0_0_00_0000_0_1) begin
            n_fail++;
            $display("FAIL rstmid_outputs got=%b exp=%b",
                     {grant, busy, done, done_id, match_cnt, det_w, det_rst}, 14'b1);
        end
        Rst = 1'b1;
        ptr_m = N - 1;
        tick;
        exp = pick(ptr_m, req);
        ptr_m = exp;
        n_cmp++;
        if (grant !== 4'(1 << exp) || det_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_restart grant=%b det_rst=%b exp=%b 1", grant, det_rst,
                     4'(1 << exp));
        end
        run_job(0, req, data, cyc, wb, rc);
        n_cmp++;
        if (cyc !== 10 || rc !== 1 || done_id !== 2'd2 ||
            match_cnt !== 4'(sat(count111(w), 4))) begin
            n_fail++;
            $display("FAIL rstmid_done cyc=%0d rst=%0d id=%0d cnt=%0d exp 10 1 2 %0d", cyc, rc,
                     done_id, match_cnt, sat(count111(w), 4));
        end
        req = '0;
        tick;
    endtask

    task automatic test_random;
        int cyc, rc, exp, c;
        logic [DW-1:0] wb, lat;
        logic [N-1:0] r;
        for (int j = 0; j < 12; j++) begin
            r = N'($urandom_range(1, (1 << N) - 1));
            req = r;
            data = {$urandom};
            tick;
            exp = pick(ptr_m, r);
            ptr_m = exp;
            lat = data[exp*DW +: DW];
            c = count111(lat);
            n_cmp++;
            if (grant !== 4'(1 << exp)) begin
                n_fail++;
                $display("FAIL rand_grant job=%0d req=%b got=%b exp=%b", j, r, grant,
                         4'(1 << exp));
            end
            run_job($urandom_range(1, 8), N'($urandom), {$urandom}, cyc, wb, rc);
            n_cmp++;
            if (cyc !== 10 || wb !== lat || done_id !== 2'(exp) ||
                match_cnt !== 4'(sat(c, 4)) || match_cnt_s !== 2'(sat(c, 2))) begin
                n_fail++;
                $display("FAIL rand_done job=%0d cyc=%0d bits=%h id=%0d cnt=%0d/%0d exp %h %0d %0d/%0d",
                         j, cyc, wb, done_id, match_cnt, match_cnt_s, lat, exp, sat(c, 4),
                         sat(c, 2));
            end
            tick;
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single(8'hFF);
        test_single(8'hE7);
        test_single(8'h00);
        test_rr();
        test_ignore();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
